// File: rtl/int_controller.sv
// Four-source prioritised interrupt controller: edge latching, enable mask,
// lowest-index arbitration and a request/ack/return handshake with the core.
module int_controller #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    irq,
  input  logic [AW-1:0] vec0,
  input  logic [AW-1:0] vec1,
  input  logic [AW-1:0] vec2,
  input  logic [AW-1:0] vec3,
  input  logic          mask_we,
  input  logic [3:0]    mask_wd,
  input  logic          int_ack,
  input  logic          reti,
  output logic          int_req,
  output logic [AW-1:0] int_vec,
  output logic [1:0]    int_id,
  output logic          in_service,
  output logic [3:0]    pending,
  output logic [3:0]    mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    irq_d;
  logic [3:0]    eligible;
  logic [3:0]    rise;
  logic [3:0]    ack_clr;
  logic [1:0]    sel;
  logic [AW-1:0] sel_vec;
  logic          load_sel;
  logic          ack_take;

  assign eligible = pending & mask;
  assign rise     = irq & ~irq_d;

  always_comb begin
    sel = 2'd3;
    if (eligible[0])      sel = 2'd0;
    else if (eligible[1]) sel = 2'd1;
    else if (eligible[2]) sel = 2'd2;
  end

  always_comb begin
    case (sel)
      2'd0:    sel_vec = vec0;
      2'd1:    sel_vec = vec1;
      2'd2:    sel_vec = vec2;
      default: sel_vec = vec3;
    endcase
  end

  // Ack wins over a same-cycle loss of eligibility: the core has already
  // pushed its PC and jumped, so the handshake must complete.
  always_comb begin
    state_nx = state;
    load_sel = 1'b0;
    ack_take = 1'b0;
    case (state)
      IDLE: begin
        if (eligible != 4'b0000) begin
          state_nx = REQ;
          load_sel = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nx = SERVICE;
          ack_take = 1'b1;
        end else if (eligible == 4'b0000) begin
          state_nx = IDLE;
        end else begin
          load_sel = 1'b1;
        end
      end
      SERVICE: begin
        if (reti) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ack_clr = ack_take ? (4'b0001 << int_id) : 4'b0000;

  // A new edge is ORed in after the ack clear so a same-cycle set survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      irq_d   <= 4'b0000;
      pending <= 4'b0000;
      mask    <= 4'b0000;
      int_id  <= 2'd0;
      int_vec <= '0;
    end else begin
      state   <= state_nx;
      irq_d   <= irq;
      pending <= (pending & ~ack_clr) | rise;
      if (mask_we) mask <= mask_wd;
      if (load_sel) begin
        int_id  <= sel;
        int_vec <= sel_vec;
      end
    end
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: directed handshake scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_int_controller;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    irq = 4'b0;
  logic [AW-1:0] vec0 = 10'h100;
  logic [AW-1:0] vec1 = 10'h155;
  logic [AW-1:0] vec2 = 10'h2AA;
  logic [AW-1:0] vec3 = 10'h3FF;
  logic          mask_we = 1'b0;
  logic [3:0]    mask_wd = 4'b0;
  logic          int_ack = 1'b0;
  logic          reti = 1'b0;
  logic          int_req;
  logic [AW-1:0] int_vec;
  logic [1:0]    int_id;
  logic          in_service;
  logic [3:0]    pending;
  logic [3:0]    mask;

  int_controller #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .vec0(vec0), .vec1(vec1), .vec2(vec2), .vec3(vec3),
    .mask_we(mask_we), .mask_wd(mask_wd), .int_ack(int_ack), .reti(reti),
    .int_req(int_req), .int_vec(int_vec), .int_id(int_id),
    .in_service(in_service), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic          svc;
    logic [1:0]    id;
    logic [AW-1:0] vec;
    logic [3:0]    pend;
    logic [3:0]    msk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  // Behavioural model: handler busy flags plus the latched edge set.
  logic [AW-1:0] vtab [4];
  logic [3:0]    m_pend, m_mask, m_prev;
  bit            m_req, m_svc;
  int            m_id;
  logic [AW-1:0] m_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pend = 4'b0; m_mask = 4'b0; m_prev = 4'b0;
    m_req = 0; m_svc = 0; m_id = 0; m_vec = '0;
  endtask

  task automatic model_update(input logic [3:0] i, input logic we, input logic [3:0] wd,
                              input logic a, input logic r);
    int best;
    logic [3:0] pend_n;
    best = -1;
    for (int k = 0; k < 4; k++)
      if (best < 0 && m_pend[k] && m_mask[k]) best = k;
    pend_n = m_pend;
    if (m_svc) begin
      if (r) m_svc = 0;
    end else if (m_req) begin
      if (a) begin
        m_req = 0; m_svc = 1; pend_n[m_id] = 1'b0;
      end else if (best < 0) begin
        m_req = 0;
      end else begin
        m_id = best; m_vec = vtab[best];
      end
    end else if (best >= 0) begin
      m_req = 1; m_id = best; m_vec = vtab[best];
    end
    m_pend = pend_n | (i & ~m_prev);
    m_prev = i;
    if (we) m_mask = wd;
  endtask

  task automatic step(input logic [3:0] i, input logic we, input logic [3:0] wd,
                      input logic a, input logic r);
    exp_t e;
    @(negedge clk);
    irq = i; mask_we = we; mask_wd = wd; int_ack = a; reti = r;
    model_update(i, we, wd, a, r);
    e.req = m_req; e.svc = m_svc; e.id = 2'(m_id); e.vec = m_vec;
    e.pend = m_pend; e.msk = m_mask;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] i);
    repeat (n) step(i, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_int_req"}, int_req, 0);
    chk({tag, "_in_service"}, in_service, 0);
    chk({tag, "_int_id"}, int_id, 0);
    chk({tag, "_int_vec"}, int_vec, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_mask"}, mask, 0);
  endtask

  // Assert reset between edges so the check proves it acts without a clock.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    irq = 4'b0; mask_we = 0; mask_wd = 4'b0; int_ack = 0; reti = 0;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("sb_int_req", int_req, mon_e.req);
        chk("sb_in_service", in_service, mon_e.svc);
        chk("sb_int_id", int_id, mon_e.id);
        chk("sb_int_vec", int_vec, mon_e.vec);
        chk("sb_pending", pending, mon_e.pend);
        chk("sb_mask", mask, mon_e.msk);
      end
    end
  end

  initial begin
    logic [3:0] ri;
    logic a, r, we;
    vtab[0] = vec0; vtab[1] = vec1; vtab[2] = vec2; vtab[3] = vec3;
    model_clear();
    #3;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    // basic handshake
    step(4'b0000, 1, 4'b0001, 0, 0);
    step(4'b0001, 0, 4'b0, 0, 0);
    step(4'b0000, 0, 4'b0, 0, 0);
    settle();
    chk("basic_req", int_req, 1);
    chk("basic_vec", int_vec, 10'h100);
    chk("basic_id", int_id, 0);
    idle(1, 4'b0);
    step(4'b0000, 0, 4'b0, 1, 0);
    settle();
    chk("basic_ack_req", int_req, 0);
    chk("basic_ack_svc", in_service, 1);
    chk("basic_ack_pend", pending, 0);
    idle(4, 4'b0);
    step(4'b0000, 0, 4'b0, 0, 1);
    settle();
    chk("basic_reti_svc", in_service, 0);

    // priority
    step(4'b0000, 1, 4'hF, 0, 0);
    step(4'b1010, 0, 4'b0, 0, 0);
    idle(2, 4'b0);
    settle();
    chk("prio_id1", int_id, 1);
    chk("prio_vec1", int_vec, 10'h155);
    step(4'b0000, 0, 4'b0, 1, 0);
    idle(1, 4'b0);
    step(4'b0000, 0, 4'b0, 0, 1);
    idle(1, 4'b0);
    settle();
    chk("prio_id3", int_id, 3);
    chk("prio_req3", int_req, 1);
    step(4'b0000, 0, 4'b0, 1, 0);
    step(4'b0000, 0, 4'b0, 0, 1);
    settle();
    chk("prio_pend_empty", pending, 0);

    // preemption while requesting
    step(4'b0100, 0, 4'b0, 0, 0);
    idle(2, 4'b0);
    step(4'b0001, 0, 4'b0, 0, 0);
    idle(2, 4'b0);
    settle();
    chk("preempt_id", int_id, 0);
    chk("preempt_vec", int_vec, 10'h100);
    step(4'b0000, 0, 4'b0, 1, 0);
    settle();
    chk("preempt_pend", pending, 4'b0100);
    step(4'b0000, 0, 4'b0, 0, 1);
    idle(2, 4'b0);
    step(4'b0000, 0, 4'b0, 1, 0);
    step(4'b0000, 0, 4'b0, 0, 1);

    // mask behaviour
    step(4'b0000, 1, 4'b0000, 0, 0);
    step(4'b0010, 0, 4'b0, 0, 0);
    idle(3, 4'b0);
    settle();
    chk("mask_pend", pending, 4'b0010);
    chk("mask_noreq", int_req, 0);
    step(4'b0000, 1, 4'b0010, 0, 0);
    idle(1, 4'b0);
    settle();
    chk("unmask_req", int_req, 1);
    step(4'b0000, 1, 4'b0000, 0, 0);
    idle(1, 4'b0);
    settle();
    chk("remask_req", int_req, 0);
    chk("remask_pend", pending, 4'b0010);
    step(4'b0000, 1, 4'b0010, 0, 0);
    idle(2, 4'b0);
    step(4'b0000, 0, 4'b0, 1, 0);
    step(4'b0000, 0, 4'b0, 0, 1);

    // ack and new edge on the same source in one cycle
    step(4'b0000, 1, 4'b0001, 0, 0);
    step(4'b0001, 0, 4'b0, 0, 0);
    idle(2, 4'b0);
    step(4'b0001, 0, 4'b0, 1, 0);
    settle();
    chk("simul_svc", in_service, 1);
    chk("simul_pend", pending, 4'b0001);
    step(4'b0000, 0, 4'b0, 0, 1);
    idle(1, 4'b0);
    settle();
    chk("simul_rereq", int_req, 1);
    step(4'b0000, 0, 4'b0, 1, 0);
    step(4'b0000, 0, 4'b0, 0, 1);

    // reset in service, then a held line
    step(4'b0001, 0, 4'b0, 0, 0);
    idle(2, 4'b0);
    step(4'b0000, 0, 4'b0, 1, 0);
    do_reset("midsvc");
    idle(10, 4'b0001);
    settle();
    chk("held_pend", pending, 4'b0001);
    chk("held_noreq", int_req, 0);
    idle(1, 4'b0);

    // randomized traffic
    ri = 4'b0;
    step(4'b0000, 1, 4'hF, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      ri = ri ^ (4'($urandom) & 4'($urandom));
      a  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      r  = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      we = ($urandom_range(0, 24) == 0);
      step(ri, we, 4'($urandom), a, r);
    end
    idle(1, ri);
    settle();
    settle();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
# int_controller

Four-source prioritised interrupt controller for the single-cycle CPU. It sits between the event sources (timer, external pins) and the core's PC/stack logic. It latches interrupt edges and applies a software-written enable mask. It then presents one request with its 10-bit handler vector and runs a request/acknowledge/return handshake, so the core can push the return PC, jump, and later pop. Only one interrupt is in service at a time; there is no nesting.

## Interface
- `AW`, default 10, width of the handler vector (matches PC/stack width).
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `irq`  in  4  interrupt lines, synchronous to `clk`, rising-edge sensitive. Bit 0 is highest priority.
- `vec0`..`vec3`  in  AW each  handler address for source 0..3, static.
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_wd`  in  4  new mask value. Bit i = 1 enables source i.
- `int_ack`  in  1  one-cycle pulse from the core: request taken, PC pushed, vector loaded.
- `reti`  in  1  one-cycle pulse from the core: return-from-interrupt executed, stack popped.
- `int_req`  out  1  request to the core.
- `int_vec`  out  AW  vector of the requested source, valid while `int_req`=1.
- `int_id`  out  2  index of the requested or in-service source.
- `in_service`  out  1  handler running.
- `pending`  out  4  latched, not yet acknowledged edges.
- `mask`  out  4  current enable mask.

## Operation
- **Edge detect:** `irq_d` registers `irq`. Bit i of `pending` is set at an edge where `irq[i]`=1 and `irq_d[i]`=0. A held-high line sets `pending` once only.
- **Mask:** on `mask_we`, `mask` is loaded with `mask_wd` on the next edge.
  - Masking a source never clears its pending bit.
  - Unmasking a pending source makes it eligible.
- **Eligibility:** eligible = `pending` & `mask`. The selected source is the lowest set index of eligible.
- **FSM states:** IDLE, REQ, SERVICE.
- **IDLE:** if eligible ≠ 0, go to REQ. On that edge, register `int_id` = selected and `int_vec` = vec[selected]. `int_ack` and `reti` are ignored.
- **REQ:** `int_req`=1. Arbitration is re-run every cycle, so `int_id`/`int_vec` update at the next edge if a higher-priority source becomes eligible.
  - If eligible becomes 0 (mask change), return to IDLE. `int_req` drops after that edge.
  - On `int_ack`: go to SERVICE, clear `pending[int_id]` (the registered id at that edge) and hold `int_id`. `reti` is ignored.
- **SERVICE:** `in_service`=1 and `int_req`=0. Pending bits keep accumulating. `int_ack` is ignored.
  - On `reti`: go to IDLE. `int_id` keeps its last value.
- **Simultaneous events:**
  - Ack-clear and a new edge on the same source in the same cycle: the set wins, so the bit stays pending.
  - `mask_we` in the same cycle as `int_ack`: the ack completes using the old eligibility.
- **Reset mid-operation:** returns to IDLE immediately and clears all state. A core still in a handler must not issue `reti` after reset (it is ignored anyway, because the FSM is in IDLE).
- `int_vec` is taken directly from the `vecN` inputs with no arithmetic, AW bits wide.

## Timing
- **Reset values:** state IDLE. `int_req`=0, `in_service`=0, `int_id`=0, `int_vec`=0, `pending`=0, `mask`=0, `irq_d`=0.
- **Request latency:** `irq[i]` rises before edge n, so `pending[i]`=1 after edge n. If enabled, `int_req`=1 with a valid vector after edge n+1. Latency is 2 cycles.
- **Ack:** `int_ack` sampled at edge m gives `int_req`=0, `in_service`=1 and the pending bit cleared after edge m.
- **Return:** `reti` sampled at edge r gives `in_service`=0 after edge r. A further eligible source gives `int_req`=1 after edge r+1.
- **Mask write:** effective on the edge that samples `mask_we`. Its effect on `int_req` appears one edge later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic handshake.** Stimulus: reset; `mask`=4'b0001, `vec0`=10'h100; pulse `irq[0]`; ack 3 cycles later; `reti` 5 cycles later. Required: `int_req`=1 two cycles after the rise with `int_vec`=10'h100 and `int_id`=0; after ack `int_req`=0, `in_service`=1, `pending`=0; after `reti` `in_service`=0.
- **Priority.** Stimulus: mask=4'hF; `irq[3]` and `irq[1]` rise together. Required: `int_id`=1 and `int_vec`=`vec1` first. After ack and `reti`, `int_id`=3 is requested one cycle later and `pending` returns to 0.
- **Preemption in REQ.** Stimulus: `irq[2]` requested, then `irq[0]` rises before ack. Required: `int_id` changes 2→0 and the vector follows; the ack clears only `pending[0]`.
- **Mask behaviour.** Stimulus: mask=0, `irq[1]` pulse. Required: `pending`=4'b0010 and `int_req` stays 0. Writing mask=4'b0010 raises `int_req` one cycle later. Masking it again in REQ drops `int_req` and keeps the pending bit.
- **Simultaneous set/clear.** Stimulus: `irq[0]` rises in the same cycle as `int_ack` for id 0. Required: `pending[0]` stays 1, SERVICE is entered, and the source is re-requested after `reti`.
- **Reset mid-service and held line.** Stimulus: assert `reset` asynchronously in SERVICE. Required: all outputs go to their reset values immediately. Holding `irq[0]` high for 10 cycles after that yields exactly one pending set.
